// File: rtl/cpe_misr_compactor.sv
// Response analyser for the CPE adder stage: folds a stream of codewords into a
// Galois MISR signature and compares it with a golden value after NPAT codewords.
module cpe_misr_compactor #(
  parameter int               NCODE = 15,
  parameter int               NPAT  = 16384,
  parameter int               CNTW  = 15,
  parameter logic [NCODE-1:0] POLY  = NCODE'(3),
  parameter logic [NCODE-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             code_valid,
  input  logic [NCODE-1:0] code,
  input  logic [NCODE-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NCODE-1:0] signature,
  output logic [CNTW-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NPAT - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NPAT);

  // Galois step: multiply by x modulo the feedback polynomial, then inject the codeword.
  function automatic logic [NCODE-1:0] misr_step(input logic [NCODE-1:0] sig,
                                                 input logic [NCODE-1:0] cw);
    logic [NCODE-1:0] fb;
    fb = sig[NCODE-1] ? POLY : '0;
    return ({sig[NCODE-2:0], 1'b0} ^ fb) ^ cw;
  endfunction

  state_t           state;
  logic [NCODE-1:0] sig_next;

  assign sig_next = misr_step(signature, code);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= SEED;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= RUN;
            busy      <= 1'b1;
            signature <= SEED;
            count     <= '0;
          end
        end
        RUN: begin
          // abort wins over absorption: the codeword presented with it is dropped
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (code_valid) begin
            signature <= sig_next;
            if (count == CNT_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden);
              count <= CNT_FULL;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SEED;
            count     <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpe_misr_compactor.sv
// Scoreboard bench for cpe_misr_compactor: four instances (NPAT = 1, 2, 4, default)
// driven by directed streams; a monitor checks each run's result when done rises.
module tb_cpe_misr_compactor;

  localparam int NI = 4;

  typedef struct {
    logic [14:0] sig;
    logic [14:0] cnt;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [NI];
  logic        abort      [NI];
  logic        code_valid [NI];
  logic [14:0] code       [NI];
  logic [14:0] golden     [NI];
  logic        busy       [NI];
  logic        done       [NI];
  logic        pass       [NI];
  logic [14:0] sig        [NI];
  logic [14:0] cnt        [NI];
  logic        done_q     [NI];

  exp_t sbq [NI][$];
  exp_t e_m;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [14:0] sig_good, sig_flip;

  always #5 clk = ~clk;

  cpe_misr_compactor #(.NPAT(1)) u_n1 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .code_valid(code_valid[0]),
    .code(code[0]), .golden(golden[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .signature(sig[0]), .count(cnt[0]));

  cpe_misr_compactor #(.NPAT(2)) u_n2 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .code_valid(code_valid[1]),
    .code(code[1]), .golden(golden[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .signature(sig[1]), .count(cnt[1]));

  cpe_misr_compactor #(.NPAT(4)) u_n4 (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .code_valid(code_valid[2]),
    .code(code[2]), .golden(golden[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .signature(sig[2]), .count(cnt[2]));

  cpe_misr_compactor u_dflt (
    .clk(clk), .rst(rst), .start(start[3]), .abort(abort[3]), .code_valid(code_valid[3]),
    .code(code[3]), .golden(golden[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
    .signature(sig[3]), .count(cnt[3]));

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] actual=0x%0h expected=0x%0h", nm, inst, act, exp);
    end
  endtask

  task automatic drv(input int i, input logic s, input logic a, input logic v,
                     input logic [14:0] c);
    @(negedge clk);
    start[i]      = s;
    abort[i]      = a;
    code_valid[i] = v;
    code[i]       = c;
  endtask

  task automatic idle(input int i);
    drv(i, 1'b0, 1'b0, 1'b0, 15'h0);
  endtask

  task automatic push(input int i, input logic [14:0] s, input logic [14:0] c, input logic p);
    exp_t e;
    e.sig  = s;
    e.cnt  = c;
    e.pass = p;
    sbq[i].push_back(e);
  endtask

  // Bit-serial reference of one MISR step for x^15+x+1.
  function automatic logic [14:0] ref_step(input logic [14:0] s, input logic [14:0] c);
    logic [14:0] n;
    logic        fb;
    fb = s[14];
    for (int k = 0; k < 15; k++) begin
      n[k] = ((k == 0) ? 1'b0 : s[k-1]) ^ ((k < 2) ? fb : 1'b0) ^ c[k];
    end
    return n;
  endfunction

  // Stand-in for the adder+CPE stage: 8-bit sum over the 7-bit xor of the operands.
  function automatic logic [14:0] gen_code(input int a, input int b);
    logic [7:0] s;
    logic [6:0] x;
    s = 8'(a) + 8'(b);
    x = 7'(a) ^ 7'(b);
    return {s, x};
  endfunction

  // Monitor: one expected result popped per rising done.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst && done[i] && !done_q[i]) begin
        if (sbq[i].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_done[%0d] actual=done expected=no result pending", i);
        end else begin
          e_m = sbq[i].pop_front();
          chk("sb_signature", i, 32'(sig[i]), 32'(e_m.sig));
          chk("sb_count", i, 32'(cnt[i]), 32'(e_m.cnt));
          chk("sb_pass", i, 32'(pass[i]), 32'(e_m.pass));
        end
      end
      done_q[i] = done[i];
    end
  end

  initial begin
    logic [14:0] c;
    int          idx;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b1; abort[i] = 1'b0; code_valid[i] = 1'b1;
      code[i] = 15'h7FFF; golden[i] = 15'h0; done_q[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", i, 32'(busy[i]), 0);
      chk("rst_done", i, 32'(done[i]), 0);
      chk("rst_pass", i, 32'(pass[i]), 0);
      chk("rst_signature", i, 32'(sig[i]), 0);
      chk("rst_count", i, 32'(cnt[i]), 0);
      start[i] = 1'b0; code_valid[i] = 1'b0; code[i] = 15'h0;
    end
    rst = 1'b0;

    // NPAT=1: single absorb, matching then mismatching golden
    golden[0] = 15'h1234;
    push(0, 15'h1234, 15'd1, 1'b1);
    drv(0, 1, 0, 0, 15'h0);
    drv(0, 0, 0, 1, 15'h1234);
    idle(0);
    chk("n1_done", 0, 32'(done[0]), 1);
    golden[0] = 15'h1235;
    push(0, 15'h1234, 15'd1, 1'b0);
    drv(0, 1, 0, 0, 15'h0);
    idle(0);
    chk("n1_restart_busy", 0, 32'(busy[0]), 1);
    drv(0, 0, 0, 1, 15'h1234);
    idle(0);

    // NPAT=2: feedback through the MSB, back-to-back then with gaps
    golden[1] = 15'h0003;
    push(1, 15'h0003, 15'd2, 1'b1);
    drv(1, 1, 0, 0, 15'h0);
    drv(1, 0, 0, 1, 15'h4000);
    idle(1);
    chk("fb_first_sig", 1, 32'(sig[1]), 32'h4000);
    chk("fb_first_done", 1, 32'(done[1]), 0);
    drv(1, 0, 0, 1, 15'h0000);
    idle(1);
    chk("fb_done_latency", 1, 32'(done[1]), 1);
    push(1, 15'h0003, 15'd2, 1'b1);
    drv(1, 1, 0, 0, 15'h0);
    idle(1);
    drv(1, 0, 0, 1, 15'h4000);
    repeat (3) idle(1);
    chk("fb_gap_sig", 1, 32'(sig[1]), 32'h4000);
    chk("fb_gap_count", 1, 32'(cnt[1]), 1);
    drv(1, 0, 0, 1, 15'h0000);
    idle(1);

    // NPAT=4: abort with a valid codeword, then restart and rerun
    golden[2] = 15'h25A1;
    drv(2, 1, 0, 0, 15'h0);
    drv(2, 0, 0, 1, 15'h4001);
    drv(2, 0, 0, 1, 15'h1111);
    drv(2, 0, 1, 1, 15'h0F0F);
    idle(2);
    chk("abort_busy", 2, 32'(busy[2]), 0);
    chk("abort_count", 2, 32'(cnt[2]), 2);
    chk("abort_sig", 2, 32'(sig[2]), 32'h1110);
    drv(2, 1, 1, 0, 15'h0);
    idle(2);
    chk("idle_abort_wins", 2, 32'(busy[2]), 0);
    drv(2, 1, 0, 0, 15'h0);
    idle(2);
    chk("reseed_sig", 2, 32'(sig[2]), 0);
    chk("reseed_count", 2, 32'(cnt[2]), 0);
    push(2, 15'h25A1, 15'd4, 1'b1);
    drv(2, 0, 0, 1, 15'h4001);
    drv(2, 0, 0, 1, 15'h1111);
    drv(2, 0, 0, 1, 15'h0F0F);
    drv(2, 0, 0, 1, 15'h7FFF);
    idle(2);
    drv(2, 0, 0, 1, 15'h1234);
    idle(2);
    chk("done_ignores_code", 2, 32'(sig[2]), 32'h25A1);
    drv(2, 1, 0, 0, 15'h0);
    idle(2);
    chk("restart_done", 2, 32'(done[2]), 0);
    chk("restart_pass", 2, 32'(pass[2]), 0);
    chk("restart_busy", 2, 32'(busy[2]), 1);
    chk("restart_sig", 2, 32'(sig[2]), 0);
    push(2, 15'h25A1, 15'd4, 1'b1);
    drv(2, 0, 0, 1, 15'h4001);
    drv(2, 0, 0, 1, 15'h1111);
    drv(2, 0, 0, 1, 15'h0F0F);
    drv(2, 0, 0, 1, 15'h7FFF);
    idle(2);
    drv(2, 1, 1, 0, 15'h0);
    idle(2);
    chk("done_abort_wins_done", 2, 32'(done[2]), 0);
    chk("done_abort_wins_busy", 2, 32'(busy[2]), 0);

    // Default NPAT: exhaustive 7-bit a,b sweep, clean then with one flipped bit
    sig_good = 15'h0;
    sig_flip = 15'h0;
    for (int a = 0; a < 128; a++) begin
      for (int b = 0; b < 128; b++) begin
        c = gen_code(a, b);
        sig_good = ref_step(sig_good, c);
        sig_flip = ref_step(sig_flip, ((a * 128 + b) == 5000) ? (c ^ 15'h0100) : c);
      end
    end
    golden[3] = sig_good;
    for (int run = 0; run < 2; run++) begin
      push(3, (run == 0) ? sig_good : sig_flip, 15'd16384, (run == 0));
      drv(3, 1, 0, 0, 15'h0);
      for (int a = 0; a < 128; a++) begin
        for (int b = 0; b < 128; b++) begin
          idx = a * 128 + b;
          c = gen_code(a, b);
          if (run == 1 && idx == 5000) c = c ^ 15'h0100;
          if (idx == 16383) begin
            idle(3);
            chk("exh_not_done_early", 3, 32'(done[3]), 0);
            chk("exh_count_before_last", 3, 32'(cnt[3]), 16383);
          end
          drv(3, 0, 0, 1, c);
        end
      end
      idle(3);
      chk("exh_done", 3, 32'(done[3]), 1);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("sb_drained", i, 32'(sbq[i].size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
